// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data ports of the core.
// Data has priority; a starvation guard bounds fetch delay, and lost accesses time out.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_err,
  output logic              i_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              d_stall,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TOUT_LIM   = 8'(TIMEOUT - 1);

  state_t     state;
  logic       own_data;
  logic       lat_we;
  logic       proto_err;
  logic [3:0] starve_cnt;
  logic [7:0] tout_cnt;
  logic       d_req;
  logic       grant_data;
  logic       grant_fetch;

  assign d_req   = d_rd | d_wr;
  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

  // Data wins unless it has already taken STARVE_MAX grants past a waiting fetch.
  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (d_req && (starve_cnt < STARVE_LIM)) grant_data = 1'b1;
    else if (i_req)                         grant_fetch = 1'b1;
    else if (d_req)                         grant_data = 1'b1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      own_data   <= 1'b0;
      lat_we     <= 1'b0;
      proto_err  <= 1'b0;
      starve_cnt <= '0;
      tout_cnt   <= '0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_err      <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      m_en   <= 1'b0;
      m_we   <= 1'b0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_err  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            own_data  <= 1'b1;
            m_addr    <= d_addr;
            m_wdata   <= d_wdata;
            lat_we    <= d_wr;
            m_we      <= d_wr;
            proto_err <= d_rd & d_wr;
            m_en      <= 1'b1;
            state     <= ISSUE;
            if (!i_req)                      starve_cnt <= '0;
            else if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_fetch) begin
            own_data   <= 1'b0;
            m_addr     <= i_addr;
            m_wdata    <= '0;
            lat_we     <= 1'b0;
            proto_err  <= 1'b0;
            m_en       <= 1'b1;
            starve_cnt <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          tout_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // A response on the final allowed cycle still counts as success.
          if (m_valid) begin
            state <= DONE;
            if (own_data) begin
              if (!lat_we) d_rdata <= m_rdata;
              d_done <= 1'b1;
              d_err  <= proto_err;
            end else begin
              i_rdata <= m_rdata;
              i_done  <= 1'b1;
            end
          end else if (tout_cnt == TOUT_LIM) begin
            state <= DONE;
            if (own_data) begin
              d_rdata <= '0;
              d_done  <= 1'b1;
              d_err   <= 1'b1;
            end else begin
              i_rdata <= '0;
              i_done  <= 1'b1;
              i_err   <= 1'b1;
            end
          end else begin
            tout_cnt <= tout_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the instruction-fetch port and the data-memory port of the pipelined MIPS core.
- Arbitrates between the two ports, sequences each access as a multi-cycle handshake, and times out lost accesses.
- Produces per-port stall signals that feed the pipeline register stall/nop controller in place of the imem/dmem miss signals.
- Data-side requests have priority. A starvation guard bounds how long instruction fetch can be delayed.

Parameters:
- ADDR_W, 32, address width for both ports and the memory side.
- DATA_W, 32, data width.
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending; range 1..15.
- TIMEOUT, 15, cycles to wait for m_valid before aborting an access; range 2..255.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_done.
- i_addr  in  ADDR_W  fetch address (PC); held stable while i_req is high.
- i_rdata  out  DATA_W  fetched instruction; valid in the i_done cycle.
- i_done  out  1  one-cycle completion pulse for a fetch.
- i_err  out  1  pulses with i_done on timeout.
- i_stall  out  1  i_req & ~i_done (combinational).
- d_rd  in  1  data read request.
- d_wr  in  1  data write request.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid in the d_done cycle.
- d_done  out  1  one-cycle completion pulse for a data access.
- d_err  out  1  pulses with d_done on timeout or on a protocol error.
- d_stall  out  1  (d_rd|d_wr) & ~d_done (combinational).
- m_en  out  1  memory access strobe, one cycle per access.
- m_we  out  1  write enable; qualified by m_en.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data; valid with m_valid.
- m_valid  in  1  memory completion; ignored except in WAIT.

Behaviour:

Reset:
- On Rst, asynchronously: state=IDLE, all outputs 0, starvation counter=0, timeout counter=0.
- Rst asserted mid-access abandons the access. No done pulse is issued for it. A late m_valid after reset is ignored.

States: IDLE, ISSUE, WAIT, DONE.

IDLE:
- If (d_rd|d_wr) and starve_cnt<STARVE_MAX, grant data.
- Else if i_req, grant fetch.
- Else if (d_rd|d_wr), grant data. This covers the case starve_cnt==STARVE_MAX with no fetch pending.
- On a grant: latch owner, address, write flag and wdata, then go to ISSUE.

ISSUE:
- m_en=1 for exactly one cycle; m_addr, m_we and m_wdata come from the latched values.
- Clear the timeout counter and go to WAIT.
- m_we=1 only when the owner is data and the access is a write.

WAIT:
- On m_valid: latch m_rdata into the owner's rdata register (writes latch nothing) and go to DONE.
- Otherwise increment the timeout counter. When it reaches TIMEOUT, load rdata=0, set err, and go to DONE.
- m_valid in the same cycle as the timeout limit counts as success.

DONE:
- The owner's done pulses for one cycle; err pulses too if set.
- Go to IDLE. No regrant is made in the DONE cycle, so the requester can drop or advance its request.

Data output hold:
- i_rdata and d_rdata hold their last value until the next completion on that port.

Starvation counter:
- A data grant with i_req high increments starve_cnt, saturating at STARVE_MAX.
- A fetch grant, or a data grant with i_req low, clears it.

Protocol error:
- d_rd and d_wr both high at grant: the access is performed as a write and d_err is pulsed with d_done.

Timing:
- Minimum latency is request sampled at edge k → m_en in cycle k+1 → m_valid earliest in cycle k+2 → done in cycle k+3.
- Back-to-back accesses from the same port are separated by at least one IDLE cycle.

Error outputs:
- Errors are not sticky.
- i_err and d_err are never high without the matching done.

Test Plan:
1. Fetch only: i_req=1, i_addr=0x0, memory returns 0x20080005 with m_valid one cycle after m_en → m_en exactly one cycle with m_addr=0x0 and m_we=0; i_done in cycle 3 with i_rdata=0x20080005; i_stall high in cycles 0–2.
2. Simultaneous i_req and d_rd, with d_addr=0x40 returning 0xDEADBEEF → data granted first (d_done, d_rdata=0xDEADBEEF), then fetch granted after one IDLE cycle.
3. Store: d_wr=1, d_addr=0x10, d_wdata=0x12345678 → m_en=1, m_we=1, m_addr=0x10, m_wdata=0x12345678; d_done after m_valid; d_rdata unchanged.
4. Starvation: d_rd held continuously with i_req pending and STARVE_MAX=4 → exactly 4 data completions, then a fetch grant; starve_cnt returns to 0.
5. Timeout: m_valid never asserted on a fetch with TIMEOUT=15 → i_done and i_err pulse together after 15 WAIT cycles with i_rdata=0; the next request is served normally.
6. Reset mid-WAIT with a data access outstanding → all outputs 0 immediately; an m_valid arriving after reset produces no done; the post-reset request completes normally.
